// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access types, MMU exception codes and the fault record layout.
package lsu_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned TAG_W_DEF  = 7;

    typedef enum logic [1:0] {
        ACC_LD   = 2'd0,
        ACC_ST   = 2'd1,
        ACC_INST = 2'd2
    } acc_type_e;

    // Encoding 3 on accType_i never names a real access.
    localparam logic [1:0] ACC_ILLEGAL = 2'd3;

    localparam logic [7:0] EXC_NONE             = 8'd0;
    localparam logic [7:0] EXC_LD_ADDR_MISALIGN = 8'd4;
    localparam logic [7:0] EXC_LD_ACCESS_FAULT  = 8'd5;
    localparam logic [7:0] EXC_ST_ACCESS_FAULT  = 8'd7;
    localparam logic [7:0] EXC_INST_PAGE_FAULT  = 8'd12;
    localparam logic [7:0] EXC_LD_PAGE_FAULT    = 8'd13;
    localparam logic [7:0] EXC_ST_PAGE_FAULT    = 8'd15;

    typedef struct packed {
        logic [7:0]            code;
        logic [ADDR_W_DEF-1:0] addr;
        logic [1:0]            acc_type;
        logic [TAG_W_DEF-1:0]  tag;
    } fault_entry_t;

endpackage

// File: rtl/fault_fifo_ram.sv
// Register-array storage for the fault queue: one synchronous write port, one asynchronous read port.
module fault_fifo_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lsu_fault_queue.sv
// In-order queue of MMU faults handed one at a time to the commit stage; emptied on recovery flush.
module lsu_fault_queue
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              accValid_i,
    input  logic [1:0]        accType_i,
    input  logic [ADDR_W-1:0] virtAddress_i,
    input  logic [TAG_W-1:0]  accTag_i,
    input  logic [7:0]        exception_i,
    output logic              full_o,
    output logic              faultValid_o,
    input  logic              faultReady_i,
    output logic [7:0]        faultCode_o,
    output logic [ADDR_W-1:0] faultAddr_o,
    output logic [1:0]        faultType_o,
    output logic [TAG_W-1:0]  faultTag_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  faultCount_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [7:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        acc_type;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_faultCount;

    logic   w_enqReq;
    logic   w_full;
    logic   w_valid;
    logic   w_deq;
    logic   w_enq;
    entry_t w_wrEntry;
    entry_t w_head;

    assign w_enqReq = accValid_i && (exception_i != EXC_NONE) && (accType_i != ACC_ILLEGAL);
    assign w_full   = (r_count == CNT_FULL);
    assign w_valid  = (r_count != '0);
    assign w_deq    = w_valid && faultReady_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_enq    = w_enqReq && (!w_full || w_deq);

    assign w_wrEntry = '{code: exception_i, addr: virtAddress_i,
                         acc_type: accType_i, tag: accTag_i};

    fault_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_ram (
        .clk     (clk),
        .i_we    (w_enq && !flush_i && !reset),
        .i_waddr (r_wrPtr),
        .i_wdata (w_wrEntry),
        .i_raddr (r_rdPtr),
        .o_rdata (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_faultCount <= '0;
        end else if (flush_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (r_faultCount != '1) begin
                    r_faultCount <= r_faultCount + 1'b1;
                end
            end
            if (w_deq) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
            if (w_enqReq && w_full && !w_deq) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign full_o       = w_full;
    assign faultValid_o = w_valid;
    assign overflow_o   = r_overflow;
    assign faultCount_o = r_faultCount;

    // Stale array contents are masked so the data outputs read 0 whenever nothing is presented.
    assign faultCode_o = w_valid ? w_head.code     : '0;
    assign faultAddr_o = w_valid ? w_head.addr     : '0;
    assign faultType_o = w_valid ? w_head.acc_type : '0;
    assign faultTag_o  = w_valid ? w_head.tag      : '0;

endmodule

// File: tb/tb_lsu_fault_queue.sv
// Scoreboard bench for lsu_fault_queue: a queue-based reference model plus a negedge monitor.
module tb_lsu_fault_queue;
    import lsu_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 7;
    localparam int unsigned CNT_W  = 16;

    typedef struct {
        logic [7:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        acc_type;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              accValid = 1'b0;
    logic [1:0]        accType = 2'd0;
    logic [ADDR_W-1:0] vaddr = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic [7:0]        exc = '0;
    logic              rdy = 1'b0;

    logic              full_o, faultValid_o, overflow_o;
    logic [7:0]        faultCode_o;
    logic [ADDR_W-1:0] faultAddr_o;
    logic [1:0]        faultType_o;
    logic [TAG_W-1:0]  faultTag_o;
    logic [CNT_W-1:0]  faultCount_o;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    exp_t             mq[$];
    bit               m_ovf = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    lsu_fault_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .TAG_W  (TAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .flush_i       (flush),
        .accValid_i    (accValid),
        .accType_i     (accType),
        .virtAddress_i (vaddr),
        .accTag_i      (tag),
        .exception_i   (exc),
        .full_o        (full_o),
        .faultValid_o  (faultValid_o),
        .faultReady_i  (rdy),
        .faultCode_o   (faultCode_o),
        .faultAddr_o   (faultAddr_o),
        .faultType_o   (faultType_o),
        .faultTag_o    (faultTag_o),
        .overflow_o    (overflow_o),
        .faultCount_o  (faultCount_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of expected faults updated on every clock edge.
    always @(posedge clk) begin
        bit deq;
        bit req;
        exp_t e;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
        end else if (flush) begin
            mq.delete();
        end else begin
            deq = (mq.size() != 0) && rdy;
            req = accValid && (exc != 8'd0) && (accType != 2'd3);
            if (deq) void'(mq.pop_front());
            if (req) begin
                if (mq.size() >= DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    e.code = exc; e.addr = vaddr; e.acc_type = accType; e.tag = tag;
                    mq.push_back(e);
                    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                end
            end
        end
    end

    // Monitor: compares the presented head with the oldest expected fault, plus status flags.
    always @(negedge clk) begin
        if (mon_en) begin
            check("faultValid", 64'(faultValid_o), 64'(mq.size() != 0));
            check("full", 64'(full_o), 64'(mq.size() == DEPTH));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            check("faultCount", 64'(faultCount_o), 64'(m_cnt));
            if (faultValid_o && mq.size() != 0) begin
                check("head_code", 64'(faultCode_o), 64'(mq[0].code));
                check("head_addr", 64'(faultAddr_o), 64'(mq[0].addr));
                check("head_type", 64'(faultType_o), 64'(mq[0].acc_type));
                check("head_tag", 64'(faultTag_o), 64'(mq[0].tag));
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] t, input logic [ADDR_W-1:0] a,
                         input logic [TAG_W-1:0] tg, input logic [7:0] e,
                         input logic r, input logic fl);
        accValid = v; accType = t; vaddr = a; tag = tg; exc = e; rdy = r; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, 2'd0, '0, '0, 8'd0, r, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        check("rst_valid", 64'(faultValid_o), 64'd0);
        check("rst_full", 64'(full_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_count", 64'(faultCount_o), 64'd0);
        check("rst_data", {faultCode_o, faultAddr_o, faultType_o, faultTag_o}, 64'd0);
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;

        // Single load page fault, then accept it.
        drive(1'b1, ACC_LD, 32'h1000, 7'd5, EXC_LD_PAGE_FAULT, 1'b0, 1'b0);
        check("first_code", 64'(faultCode_o), 64'd13);
        check("first_addr", 64'(faultAddr_o), 64'h1000);
        check("first_tag", 64'(faultTag_o), 64'd5);
        idle(1'b1);
        check("first_drained", 64'(faultValid_o), 64'd0);
        check("first_count", 64'(faultCount_o), 64'd1);

        // Non-faulting accesses are not stored.
        do_reset();
        for (int i = 0; i < 10; i++)
            drive(1'b1, 2'($urandom_range(0, 2)), $urandom, 7'($urandom), 8'd0, 1'b0, 1'b0);
        check("nofault_count", 64'(faultCount_o), 64'd0);
        check("nofault_valid", 64'(faultValid_o), 64'd0);

        // Fill, overflow, drain in order.
        for (int i = 1; i <= 4; i++)
            drive(1'b1, ACC_ST, 32'h2000 + 32'(i), 7'(i), EXC_ST_PAGE_FAULT, 1'b0, 1'b0);
        check("fill_full", 64'(full_o), 64'd1);
        drive(1'b1, ACC_ST, 32'h2005, 7'd5, EXC_ST_PAGE_FAULT, 1'b0, 1'b0);
        check("drop_ovf", 64'(overflow_o), 64'd1);
        check("drop_count", 64'(faultCount_o), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_tag", 64'(faultTag_o), 64'(i));
            idle(1'b1);
        end

        // Full with simultaneous enqueue and dequeue.
        do_reset();
        for (int i = 1; i <= 4; i++)
            drive(1'b1, ACC_LD, 32'h3000 + 32'(i), 7'(i), EXC_LD_ACCESS_FAULT, 1'b0, 1'b0);
        drive(1'b1, ACC_LD, 32'h3009, 7'd9, EXC_LD_ACCESS_FAULT, 1'b1, 1'b0);
        check("swap_full", 64'(full_o), 64'd1);
        check("swap_ovf", 64'(overflow_o), 64'd0);
        check("swap_head", 64'(faultTag_o), 64'd2);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("swap_empty", 64'(faultValid_o), 64'd0);

        // Flush discards queued entries and a same-cycle fault.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b1, ACC_INST, 32'h4000 + 32'(i), 7'(i), EXC_INST_PAGE_FAULT, 1'b0, 1'b0);
        drive(1'b1, ACC_LD, 32'h4100, 7'd9, EXC_LD_PAGE_FAULT, 1'b1, 1'b1);
        check("flush_valid", 64'(faultValid_o), 64'd0);
        check("flush_full", 64'(full_o), 64'd0);
        check("flush_count", 64'(faultCount_o), 64'd3);

        // Stalled head, then streaming traffic across pointer wrap; illegal type ignored.
        drive(1'b1, ACC_LD, 32'h5000, 7'd20, EXC_LD_ADDR_MISALIGN, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        drive(1'b1, 2'd3, 32'h5555, 7'd99, EXC_LD_PAGE_FAULT, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            drive(1'b1, ACC_ST, 32'h6000 + 32'(i * 8), 7'(30 + i), EXC_ST_ACCESS_FAULT, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("wrap_empty", 64'(faultValid_o), 64'd0);
        check("wrap_count", 64'(faultCount_o), 64'd11);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 7'($urandom),
                  ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'd0,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("final_empty", 64'(faultValid_o), 64'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
